dac_wave_gen: RTL and testbench
===============================

Name: dac_wave_gen

Overview:
Upstream sample source for the DAC7611 serial driver stage. Generates 12-bit DAC codes at a programmable sample rate from a phase accumulator. Supported waveforms are ramp, triangle, square and constant. Codes are presented on a valid/ready handshake that the serializer consumes, one frame per accepted sample.

Parameters:
PHASE_W, 24, phase accumulator width; must be >= DATA_W.
DATA_W, 12, DAC code width. Top DATA_W bits of the phase form the waveform index p.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
enable  input  1  run request; level-sensitive
mode  input  2  0=RAMP, 1=TRIANGLE, 2=SQUARE, 3=CONST
step  input  PHASE_W  phase increment per sample tick
rate_div  input  16  sample period = rate_div+1 clk cycles
const_code  input  DATA_W  output code in CONST mode
sample_data  output  DATA_W  DAC code to serializer
sample_valid  output  1  sample_data holds an unaccepted sample
sample_ready  input  1  serializer accepts sample when valid&&ready
overrun  output  1  sticky: a tick occurred while a sample was still pending
running  output  1  high in RUN state

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, phase=0, div_cnt=0.
  - sample_data=0, sample_valid=0, overrun=0, running=0.
- States:
  - IDLE: phase=0, div_cnt=0. enable=1 -> RUN.
  - RUN: running=1.
    - enable=0 with sample_valid&&!sample_ready -> STOP.
    - enable=0 otherwise -> IDLE.
  - STOP: no ticks. Go to IDLE on the cycle the pending sample is accepted. enable is ignored in STOP.
- Divider (RUN only):
  - tick = (div_cnt==0).
  - On tick, div_cnt <= rate_div; otherwise div_cnt <= div_cnt-1.
  - The first RUN cycle always ticks. Ticks repeat every rate_div+1 cycles; rate_div=0 ticks every cycle.
- On tick:
  - code is computed from the current phase, then phase <= phase+step, with modulo 2^PHASE_W wrap.
  - mode, step, const_code and rate_div are sampled at the tick; changes take effect at the next tick.
  - The first sample after entering RUN is the code for phase 0.
- Code functions, with p = phase[PHASE_W-1 -: DATA_W]:
  - RAMP: p.
  - TRIANGLE: p[MSB] ? ~{p[MSB-1:0],1'b0} : {p[MSB-1:0],1'b0}.
  - SQUARE: p[MSB] ? all-ones : 0.
  - CONST: const_code.
- Output register:
  - The register loads on a tick if !sample_valid or sample_ready in the same cycle (simultaneous accept and load is allowed, no bubble).
  - sample_data and sample_valid update on the clk edge after the tick (latency 1).
  - On accept without a new load, sample_valid <= 0.
  - sample_data holds its last value when not valid.
- Overrun:
  - A tick with sample_valid&&!sample_ready drops that sample and sets overrun=1. Phase still advances, so the waveform stays time-aligned.
  - overrun clears only in IDLE or on reset.
- sample_valid never drops without acceptance, except on reset.

Optional Feature:
DAC_GEN_OFFSET_EN
- Defined:
  - Adds port offset (input, DATA_W+1, signed two's complement), sampled at the tick.
  - code_out = saturate(code + offset) to 0..2^DATA_W-1.
  - Offset is applied in all modes, including CONST.
- Undefined:
  - The offset port is absent.
  - code_out = code, no adder in the path.

Test Plan:
- Ramp: mode=0, step=24'h001000, rate_div=3, ready=1, enable=1.
  - Expect sample_valid pulses every 4 cycles.
  - Expect sample_data = 0,1,2,3,...
  - First valid occurs 2 edges after enable is sampled.
- Triangle: mode=1, step=24'h100000, rate_div=0, ready=1.
  - Expect data 0,512,1024,...,3584,4095,3583,...,511, then back to 0 after 16 samples.
- Square and wrap: mode=2, step=24'h400000.
  - Expect 0,0,4095,4095 repeating.
  - Phase wraps without glitch.
- Overrun/backpressure: rate_div=0, ramp step 24'h001000, ready=0 for 5 cycles.
  - Expect sample_data=0 held and valid=1 throughout.
  - Expect overrun=1 from the second tick onward.
  - After ready=1, the next accepted sample is 5 (phase advanced).
- Stop/restart: with a sample pending, drop enable.
  - Expect STOP with running=0 and valid held.
  - Accept -> IDLE, overrun=0.
  - Re-enable -> first sample 0.
- Reset mid-run: assert reset=0 during RUN with valid=1.
  - Expect all outputs 0 immediately (async).
  - After release and enable, the first sample is 0.
- With DAC_GEN_OFFSET_EN: CONST 4000 with offset +200 -> 4095; CONST 100 with offset -300 -> 0.

Source files
------------

// File: rtl/dac_wave_gen.sv
// Phase-accumulator waveform source (ramp/triangle/square/const) feeding a DAC serializer
// over valid/ready. Define DAC_GEN_OFFSET_EN to add a saturating signed offset port.
module dac_wave_gen #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] step,
  input  logic [15:0]        rate_div,
  input  logic [DATA_W-1:0]  const_code,
`ifdef DAC_GEN_OFFSET_EN
  input  logic [DATA_W:0]    offset,
`endif
  output logic [DATA_W-1:0]  sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               running
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]         r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [15:0]        r_div_cnt;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_overrun;

  logic               w_tick;
  logic               w_load;
  logic               w_accept;
  logic [DATA_W-1:0]  w_p;
  logic [DATA_W-1:0]  w_code;
  logic [DATA_W-1:0]  w_code_out;

  // The exit cycle (enable low) never ticks, so leaving RUN cannot load a fresh sample.
  assign w_tick   = (r_state == ST_RUN) && enable && (r_div_cnt == 16'd0);
  assign w_load   = w_tick && (!r_valid || sample_ready);
  assign w_accept = r_valid && sample_ready;
  assign w_p      = r_phase[PHASE_W-1 -: DATA_W];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_code = const_code;
    case (mode)
      2'd0:    w_code = w_p;
      2'd1:    w_code = w_p[DATA_W-1] ? ~{w_p[DATA_W-2:0], 1'b0} : {w_p[DATA_W-2:0], 1'b0};
      2'd2:    w_code = {DATA_W{w_p[DATA_W-1]}};
      default: w_code = const_code;
    endcase
  end

`ifdef DAC_GEN_OFFSET_EN
  logic signed [DATA_W+1:0] w_sum;

  assign w_sum = $signed({2'b00, w_code}) + $signed({offset[DATA_W], offset});

  always_comb begin
    w_code_out = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W+1])
      w_code_out = '0;
    else if (w_sum[DATA_W])
      w_code_out = '1;
  end
`else
  assign w_code_out = w_code;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_div_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_phase   <= '0;
          r_div_cnt <= '0;
          if (enable)
            r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            r_state <= (r_valid && !sample_ready) ? ST_STOP : ST_IDLE;
          end else if (w_tick) begin
            r_div_cnt <= rate_div;
            r_phase   <= r_phase + step;
          end else begin
            r_div_cnt <= r_div_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_accept)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Accept and reload may coincide; a tick that finds a pending sample drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_code_out;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (r_state == ST_IDLE)
        r_overrun <= 1'b0;
      else if (w_tick && r_valid && !sample_ready)
        r_overrun <= 1'b1;
    end
  end

  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign running      = (r_state == ST_RUN);

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: ramp, triangle, square, overrun, stop/restart, async reset,
// plus the saturating offset when DAC_GEN_OFFSET_EN is defined.
module tb_dac_wave_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] step = '0;
  logic [15:0] rate_div = '0;
  logic [11:0] const_code = '0;
  logic        sample_ready = 1'b0;
`ifdef DAC_GEN_OFFSET_EN
  logic [12:0] offset = '0;
`endif
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        overrun;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;

  dac_wave_gen #(.PHASE_W(24), .DATA_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .step         (step),
    .rate_div     (rate_div),
    .const_code   (const_code),
`ifdef DAC_GEN_OFFSET_EN
    .offset       (offset),
`endif
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    enable       = 1'b0;
    sample_ready = 1'b1;
    for (int i = 0; i < 8 && running; i++) cyc();
    cyc();
    n_cmp++;
    if (running !== 1'b0 || sample_valid !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL go_idle: running=%0b valid=%0b overrun=%0b, required 0/0/0",
               running, sample_valid, overrun);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    cyc();
    n_cmp++;
    if ({sample_data, sample_valid, overrun, running} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_state: data=%0d valid=%0b ovr=%0b run=%0b, required all 0",
               sample_data, sample_valid, overrun, running);
    end
    #2 reset = 1'b1;
    cyc();
    n_cmp++;
    if (running !== 1'b0 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: run=%0b valid=%0b, required 0/0", running, sample_valid);
    end
  endtask

  task automatic test_ramp();
    bit exp_v;
    int exp_d;
    mode = 2'd0; step = 24'h001000; rate_div = 16'd3; sample_ready = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      cyc();
      exp_v = (k >= 2) && ((k - 2) % 4 == 0);
      exp_d = (k >= 2) ? (k - 2) / 4 : 0;
      n_cmp++;
      if (sample_valid !== exp_v || sample_data !== 12'(exp_d) || running !== 1'b1) begin
        n_err++;
        $display("FAIL ramp cycle %0d: valid=%0b data=%0d run=%0b, required %0b/%0d/1",
                 k, sample_valid, sample_data, running, exp_v, exp_d);
      end
    end
    go_idle();
  endtask

  task automatic test_triangle();
    int tri_exp [17] = '{0, 512, 1024, 1536, 2048, 2560, 3072, 3584,
                         4095, 3583, 3071, 2559, 2047, 1535, 1023, 511, 0};
    mode = 2'd1; step = 24'h100000; rate_div = 16'd0; sample_ready = 1'b1; enable = 1'b1;
    cyc();
    for (int k = 0; k < 17; k++) begin
      cyc();
      n_cmp++;
      if (sample_valid !== 1'b1 || sample_data !== 12'(tri_exp[k])) begin
        n_err++;
        $display("FAIL triangle sample %0d: valid=%0b data=%0d, required 1/%0d",
                 k, sample_valid, sample_data, tri_exp[k]);
      end
    end
    go_idle();
  endtask

  task automatic test_square();
    int exp_d;
    mode = 2'd2; step = 24'h400000; rate_div = 16'd0; sample_ready = 1'b1; enable = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      exp_d = ((k % 4) >= 2) ? 4095 : 0;
      n_cmp++;
      if (sample_valid !== 1'b1 || sample_data !== 12'(exp_d)) begin
        n_err++;
        $display("FAIL square sample %0d: valid=%0b data=%0d, required 1/%0d",
                 k, sample_valid, sample_data, exp_d);
      end
    end
    go_idle();
  endtask

  task automatic test_overrun();
    mode = 2'd0; step = 24'h001000; rate_div = 16'd0; sample_ready = 1'b0; enable = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_cmp++;
      if (sample_valid !== 1'b1 || sample_data !== 12'd0 || overrun !== (k >= 1)) begin
        n_err++;
        $display("FAIL overrun hold %0d: valid=%0b data=%0d ovr=%0b, required 1/0/%0b",
                 k, sample_valid, sample_data, overrun, (k >= 1));
      end
    end
    sample_ready = 1'b1;
    cyc();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 12'd5 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun resume: valid=%0b data=%0d ovr=%0b, required 1/5/1",
               sample_valid, sample_data, overrun);
    end
    cyc();
    n_cmp++;
    if (sample_data !== 12'd6) begin
      n_err++;
      $display("FAIL overrun next: data=%0d, required 6", sample_data);
    end
  endtask

  task automatic test_stop_restart();
    sample_ready = 1'b0; enable = 1'b0;
    cyc();
    n_cmp++;
    if (running !== 1'b0 || sample_valid !== 1'b1 || sample_data !== 12'd6) begin
      n_err++;
      $display("FAIL stop_enter: run=%0b valid=%0b data=%0d, required 0/1/6",
               running, sample_valid, sample_data);
    end
    enable = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (running !== 1'b0 || sample_valid !== 1'b1 || sample_data !== 12'd6) begin
      n_err++;
      $display("FAIL stop_ignores_enable: run=%0b valid=%0b data=%0d, required 0/1/6",
               running, sample_valid, sample_data);
    end
    enable = 1'b0; sample_ready = 1'b1;
    cyc();
    n_cmp++;
    if (sample_valid !== 1'b0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL stop_accept: valid=%0b run=%0b, required 0/0", sample_valid, running);
    end
    cyc();
    n_cmp++;
    if (overrun !== 1'b0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL idle_clears_overrun: ovr=%0b run=%0b, required 0/0", overrun, running);
    end
    mode = 2'd0; step = 24'h001000; rate_div = 16'd0; enable = 1'b1;
    cyc();
    n_cmp++;
    if (running !== 1'b1 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL restart_run: run=%0b valid=%0b, required 1/0", running, sample_valid);
    end
    cyc();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 12'd0) begin
      n_err++;
      $display("FAIL restart_first: valid=%0b data=%0d, required 1/0", sample_valid, sample_data);
    end
    cyc();
    n_cmp++;
    if (sample_data !== 12'd1) begin
      n_err++;
      $display("FAIL restart_second: data=%0d, required 1", sample_data);
    end
  endtask

  task automatic test_reset_mid_run();
    sample_ready = 1'b0;
    cyc();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 12'd1 || overrun !== 1'b1 || running !== 1'b1) begin
      n_err++;
      $display("FAIL premid_state: valid=%0b data=%0d ovr=%0b run=%0b, required 1/1/1/1",
               sample_valid, sample_data, overrun, running);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({sample_data, sample_valid, overrun, running} !== 15'd0) begin
      n_err++;
      $display("FAIL async_reset: data=%0d valid=%0b ovr=%0b run=%0b, required all 0",
               sample_data, sample_valid, overrun, running);
    end
    #2 reset = 1'b1;
    sample_ready = 1'b1;
    cyc();
    n_cmp++;
    if (running !== 1'b1 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_run: run=%0b valid=%0b, required 1/0", running, sample_valid);
    end
    cyc();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 12'd0) begin
      n_err++;
      $display("FAIL post_reset_first: valid=%0b data=%0d, required 1/0", sample_valid, sample_data);
    end
    cyc();
    n_cmp++;
    if (sample_data !== 12'd1) begin
      n_err++;
      $display("FAIL post_reset_second: data=%0d, required 1", sample_data);
    end
    go_idle();
  endtask

`ifdef DAC_GEN_OFFSET_EN
  task automatic test_offset();
    mode = 2'd3; rate_div = 16'd0; sample_ready = 1'b1;
    const_code = 12'd4000; offset = 13'sd200; enable = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (sample_valid !== 1'b1 || sample_data !== 12'd4095) begin
      n_err++;
      $display("FAIL offset_sat_high: valid=%0b data=%0d, required 1/4095", sample_valid, sample_data);
    end
    const_code = 12'd100; offset = -13'sd300;
    cyc();
    n_cmp++;
    if (sample_data !== 12'd0) begin
      n_err++;
      $display("FAIL offset_sat_low: data=%0d, required 0", sample_data);
    end
    const_code = 12'd1000;
    cyc();
    n_cmp++;
    if (sample_data !== 12'd700) begin
      n_err++;
      $display("FAIL offset_plain: data=%0d, required 700", sample_data);
    end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_triangle();
    test_square();
    test_overrun();
    test_stop_restart();
    test_reset_mid_run();
`ifdef DAC_GEN_OFFSET_EN
    test_offset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
